// File: rtl/pipe_fetch_ctrl_if.sv
// Fetch-control bus between the fetch sequencer and the IF/PC datapath.
// Carries IF decode flags and the EX branch result in, and the PC and issue controls out.
interface pipe_fetch_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             hold;
  logic             beq_if;
  logic             bne_if;
  logic             j_if;
  logic             jal_if;
  logic             jr_if;
  logic             lw_if;
  logic             branch_taken_ex;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             issue_valid;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output hold, beq_if, bne_if, j_if, jal_if, jr_if, lw_if, branch_taken_ex,
    input  pc_en, pc_sel, issue_valid, busy, stall_count
  );

  modport slave (
    input  hold, beq_if, bne_if, j_if, jal_if, jr_if, lw_if, branch_taken_ex,
    output pc_en, pc_sel, issue_valid, busy, stall_count
  );
endinterface

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage sequencer: decides PC load, next-PC source and IF issue/bubble each cycle,
// covering branch, JR and load-use penalties plus an external hold; counts stall cycles.
module pipe_fetch_ctrl #(
  parameter int unsigned LW_STALL = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pipe_fetch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_RUN,
    S_BR1,
    S_BR2,
    S_JR1,
    S_LD
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_JMP = 2'b10,
    SEL_JR  = 2'b11
  } pc_sel_e;

  // LW_STALL is at most 15, so the remaining-bubble counter fits in 4 bits.
  localparam int unsigned     LD_W    = 4;
  localparam logic [LD_W-1:0] LD_INIT = LD_W'(LW_STALL - 1);

  state_e           state_q, state_d;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             pc_en;
  pc_sel_e          pc_sel;
  logic             issue_valid;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    pc_en       = 1'b0;
    pc_sel      = SEL_SEQ;
    issue_valid = 1'b0;

    // Reset and hold both leave the defaults: PC frozen, bubble issued, state kept.
    if (reset_n && !bus.hold) begin
      case (state_q)
        S_RUN: begin
          issue_valid = 1'b1;
          if (bus.jr_if) begin
            state_d = S_JR1;
          end else if (bus.beq_if || bus.bne_if) begin
            state_d = S_BR1;
          end else if (bus.lw_if) begin
            state_d  = S_LD;
            ld_cnt_d = LD_INIT;
          end else begin
            pc_en = 1'b1;
            if (bus.j_if || bus.jal_if) pc_sel = SEL_JMP;
          end
        end
        S_BR1: state_d = S_BR2;
        S_BR2: begin
          pc_en   = 1'b1;
          pc_sel  = bus.branch_taken_ex ? SEL_BR : SEL_SEQ;
          state_d = S_RUN;
        end
        S_JR1: begin
          pc_en   = 1'b1;
          pc_sel  = SEL_JR;
          state_d = S_RUN;
        end
        S_LD: begin
          if (ld_cnt_q == '0) begin
            pc_en   = 1'b1;
            state_d = S_RUN;
          end else begin
            ld_cnt_d = ld_cnt_q - 1'b1;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_en && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      state_q       <= S_RUN;
      ld_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ld_cnt_q      <= ld_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.pc_sel      = pc_sel;
  assign bus.issue_valid = issue_valid;
  assign bus.busy        = reset_n && (state_q != S_RUN);
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Bench for pipe_fetch_ctrl: two instances (LW_STALL=3/CNT_W=16 and LW_STALL=1/CNT_W=4)
// share directed and random stimulus and are compared every cycle against a plan-queue model.
module tb_pipe_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, hold, beq, bne, j, jal, jr, lw, bt;

  pipe_fetch_ctrl_if #(.CNT_W(16)) ia ();
  pipe_fetch_ctrl_if #(.CNT_W(4))  ib ();

  assign ia.hold = hold;  assign ia.beq_if = beq;  assign ia.bne_if = bne;
  assign ia.j_if = j;     assign ia.jal_if = jal;  assign ia.jr_if = jr;
  assign ia.lw_if = lw;   assign ia.branch_taken_ex = bt;
  assign ib.hold = hold;  assign ib.beq_if = beq;  assign ib.bne_if = bne;
  assign ib.j_if = j;     assign ib.jal_if = jal;  assign ib.jr_if = jr;
  assign ib.lw_if = lw;   assign ib.branch_taken_ex = bt;

  pipe_fetch_ctrl #(.LW_STALL(3), .CNT_W(16)) dut_a (.clk(clk), .reset_n(rst_n), .bus(ia));
  pipe_fetch_ctrl #(.LW_STALL(1), .CNT_W(4))  dut_b (.clk(clk), .reset_n(rst_n), .bus(ib));

  // Model: a queue of the cycles still owed by the instruction that left RUN.
  typedef enum int {K_BUBBLE, K_BR, K_JR, K_SEQ} kind_e;
  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       iv;
    logic       busy;
  } exp_t;

  kind_e plan [2][$];
  int    cnt  [2];
  int    errors = 0;
  int    checks = 0;

  localparam bit [5:0] F_NONE = 6'b000000;
  localparam bit [5:0] F_JR   = 6'b100000;
  localparam bit [5:0] F_BEQ  = 6'b010000;
  localparam bit [5:0] F_BNE  = 6'b001000;
  localparam bit [5:0] F_LW   = 6'b000100;
  localparam bit [5:0] F_J    = 6'b000010;
  localparam bit [5:0] F_JAL  = 6'b000001;

  function automatic int lw_of(int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic int max_of(int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  function automatic exp_t predict(int i);
    exp_t e;
    e = '0;
    if (!rst_n) return e;
    if (hold) begin
      e.busy = (plan[i].size() != 0);
      return e;
    end
    if (plan[i].size() == 0) begin
      e.iv = 1'b1;
      if (!(jr || beq || bne || lw)) begin
        e.pc_en  = 1'b1;
        e.pc_sel = (j || jal) ? 2'b10 : 2'b00;
      end
    end else begin
      e.busy = 1'b1;
      case (plan[i][0])
        K_BUBBLE: e.pc_en = 1'b0;
        K_BR:     begin e.pc_en = 1'b1; e.pc_sel = bt ? 2'b01 : 2'b00; end
        K_JR:     begin e.pc_en = 1'b1; e.pc_sel = 2'b11; end
        default:  e.pc_en = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic advance(int i, logic pc_en_exp);
    if (!rst_n) begin
      plan[i].delete();
      cnt[i] = 0;
      return;
    end
    if (!pc_en_exp && cnt[i] < max_of(i)) cnt[i]++;
    if (hold) return;
    if (plan[i].size() != 0) begin
      void'(plan[i].pop_front());
    end else if (jr) begin
      plan[i].push_back(K_JR);
    end else if (beq || bne) begin
      plan[i].push_back(K_BUBBLE);
      plan[i].push_back(K_BR);
    end else if (lw) begin
      for (int k = 1; k < lw_of(i); k++) plan[i].push_back(K_BUBBLE);
      plan[i].push_back(K_SEQ);
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit r, bit h, bit [5:0] f, bit t);
    rst_n = r;
    hold  = h;
    {jr, beq, bne, lw, j, jal} = f;
    bt    = t;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    exp_t ea, eb;
    #1;
    ea = predict(0);
    eb = predict(1);
    check("a_pc_en",  32'(ia.pc_en),       32'(ea.pc_en));
    check("a_pc_sel", 32'(ia.pc_sel),      32'(ea.pc_sel));
    check("a_issue",  32'(ia.issue_valid), 32'(ea.iv));
    check("a_busy",   32'(ia.busy),        32'(ea.busy));
    check("a_stall",  32'(ia.stall_count), 32'(cnt[0]));
    check("b_pc_en",  32'(ib.pc_en),       32'(eb.pc_en));
    check("b_pc_sel", 32'(ib.pc_sel),      32'(eb.pc_sel));
    check("b_issue",  32'(ib.issue_valid), 32'(eb.iv));
    check("b_busy",   32'(ib.busy),        32'(eb.busy));
    check("b_stall",  32'(ib.stall_count), 32'(cnt[1]));
    @(posedge clk);
    advance(0, ea.pc_en);
    advance(1, eb.pc_en);
    @(negedge clk);
  endtask

  initial begin
    bit [5:0] f;

    // Reset with all flags high; the first edge only clears the power-up X state.
    drive(1'b0, 1'b0, 6'b111111, 1'b1);
    @(posedge clk);
    advance(0, 1'b0);
    advance(1, 1'b0);
    @(negedge clk);
    tick();
    tick();

    drive(1'b1, 1'b0, F_NONE, 1'b0); tick();

    // Taken BEQ, then not-taken BNE.
    drive(1'b1, 1'b0, F_BEQ, 1'b1);  tick();
    drive(1'b1, 1'b0, F_NONE, 1'b1); tick(); tick();
    drive(1'b1, 1'b0, F_BNE, 1'b0);  tick();
    drive(1'b1, 1'b0, F_NONE, 1'b0); tick(); tick();

    // JR with a hold cycle while in JR1.
    drive(1'b1, 1'b0, F_JR, 1'b0);   tick();
    drive(1'b1, 1'b1, F_JR, 1'b0);   tick();
    drive(1'b1, 1'b0, F_NONE, 1'b0); tick(); tick();

    // Load-use stall.
    drive(1'b1, 1'b0, F_LW, 1'b0);   tick();
    drive(1'b1, 1'b0, F_NONE, 1'b0); repeat (4) tick();

    // Zero-penalty jumps and decode priority.
    drive(1'b1, 1'b0, F_J, 1'b0);          tick();
    drive(1'b1, 1'b0, F_JAL, 1'b0);        tick();
    drive(1'b1, 1'b0, F_JR | F_BEQ, 1'b1); tick();
    drive(1'b1, 1'b0, F_NONE, 1'b1);       tick(); tick();
    drive(1'b1, 1'b0, F_LW | F_J, 1'b0);   tick();
    drive(1'b1, 1'b0, F_NONE, 1'b0);       repeat (4) tick();

    // Reset while the branch sits in BR1: no redirect may follow.
    drive(1'b1, 1'b0, F_BEQ, 1'b1);  tick();
    drive(1'b0, 1'b0, F_NONE, 1'b1); tick();
    drive(1'b1, 1'b0, F_NONE, 1'b1); repeat (3) tick();

    // Long hold: the 4-bit counter must stop at 15.
    drive(1'b1, 1'b1, 6'b111111, 1'b1); repeat (20) tick();
    #1;
    check("b_stall_saturated", 32'(ib.stall_count), 32'd15);

    // Random traffic.
    repeat (1500) begin
      for (int k = 0; k < 6; k++) f[k] = ($urandom_range(5) == 0);
      drive(($urandom_range(63) != 0), ($urandom_range(7) == 0), f, 1'($urandom_range(1)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
